// File: rtl/colour_sensor_pkg.sv
//==============================================================================
// Module   : colour_sensor_pkg
// Brief    : Shared scan-FSM states, filter-select codes and colour class ranges.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package colour_sensor_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_SETTLE   = 3'd1,
      ST_GATE     = 3'd2,
      ST_LATCH    = 3'd3,
      ST_CLASSIFY = 3'd4
   } scan_state_t;

   // {S3,S2} codes in scan order
   localparam logic [1:0] c_filt_red   = 2'b00;
   localparam logic [1:0] c_filt_blue  = 2'b10;
   localparam logic [1:0] c_filt_green = 2'b11;
   localparam logic [1:0] c_filt_clear = 2'b01;

   localparam logic [2:0] c_class_none  = 3'b000;
   localparam logic [2:0] c_class_red   = 3'b001;
   localparam logic [2:0] c_class_blue  = 3'b010;
   localparam logic [2:0] c_class_green = 3'b100;

   // Inclusive count windows {R, B, G} that define each class
   localparam int unsigned c_red_r_lo   = 6;
   localparam int unsigned c_red_r_hi   = 9;
   localparam int unsigned c_red_b_lo   = 10;
   localparam int unsigned c_red_b_hi   = 15;
   localparam int unsigned c_red_g_lo   = 1;
   localparam int unsigned c_red_g_hi   = 3;

   localparam int unsigned c_blue_r_lo  = 0;
   localparam int unsigned c_blue_r_hi  = 5;
   localparam int unsigned c_blue_b_lo  = 20;
   localparam int unsigned c_blue_b_hi  = 60;
   localparam int unsigned c_blue_g_lo  = 0;
   localparam int unsigned c_blue_g_hi  = 9;

   localparam int unsigned c_green_r_lo = 0;
   localparam int unsigned c_green_r_hi = 5;
   localparam int unsigned c_green_b_lo = 0;
   localparam int unsigned c_green_b_hi = 9;
   localparam int unsigned c_green_g_lo = 20;
   localparam int unsigned c_green_g_hi = 60;

   function automatic logic [1:0] filt_code(input logic [1:0] idx);
      logic [1:0] code;
      case (idx)
         2'd0:    code = c_filt_red;
         2'd1:    code = c_filt_blue;
         2'd2:    code = c_filt_green;
         default: code = c_filt_clear;
      endcase
      return code;
   endfunction

   function automatic logic in_range(input int unsigned v, input int unsigned lo,
                                     input int unsigned hi);
      return (v >= lo) && (v <= hi);
   endfunction

   // Red wins over green, green over blue when windows overlap
   function automatic logic [2:0] classify(input int unsigned r, input int unsigned b,
                                           input int unsigned g);
      logic [2:0] cls;
      cls = c_class_none;
      if (in_range(r, c_red_r_lo, c_red_r_hi) && in_range(b, c_red_b_lo, c_red_b_hi) &&
          in_range(g, c_red_g_lo, c_red_g_hi))
         cls = c_class_red;
      else if (in_range(r, c_green_r_lo, c_green_r_hi) &&
               in_range(b, c_green_b_lo, c_green_b_hi) &&
               in_range(g, c_green_g_lo, c_green_g_hi))
         cls = c_class_green;
      else if (in_range(r, c_blue_r_lo, c_blue_r_hi) &&
               in_range(b, c_blue_b_lo, c_blue_b_hi) &&
               in_range(g, c_blue_g_lo, c_blue_g_hi))
         cls = c_class_blue;
      return cls;
   endfunction

endpackage

`default_nettype wire

// File: rtl/freq_edge_counter.sv
//==============================================================================
// Module   : freq_edge_counter
// Brief    : Synchronises the sensor output and counts its rising edges, saturating.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module freq_edge_counter #(
   parameter int CNT_W = 7
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             signal,
   input  logic             count_en,
   input  logic             clear,
   output logic [CNT_W-1:0] count,
   output logic             sat
);

   localparam logic [CNT_W-1:0] c_cnt_max = '1;

   logic r_sync1;
   logic r_sync2;
   logic r_prev;
   logic w_rise;

   assign w_rise = r_sync2 & ~r_prev;
   assign sat    = (count == c_cnt_max);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_prev  <= 1'b0;
         count   <= '0;
      end else begin
         r_sync1 <= signal;
         r_sync2 <= r_sync1;
         r_prev  <= r_sync2;
         if (clear)
            count <= '0;
         else if (count_en && w_rise && (count != c_cnt_max))
            count <= count + 1'b1;
      end
   end

endmodule

`default_nettype wire

// File: rtl/colour_sensor_scan.sv
//==============================================================================
// Module   : colour_sensor_scan
// Brief    : Scans colour-sensor filters, gates edge counts and confirms a colour class.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module colour_sensor_scan
   import colour_sensor_pkg::*;
#(
   parameter int GATE_CYCLES   = 100000,
   parameter int SETTLE_CYCLES = 1000,
   parameter int CNT_W         = 7,
   parameter int N_FILT        = 3,
   parameter int CONFIRM       = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [1:0]       scale,
   input  logic             signal,
   output logic             S0,
   output logic             S1,
   output logic             S2,
   output logic             S3,
   output logic [CNT_W-1:0] red_cnt,
   output logic [CNT_W-1:0] blue_cnt,
   output logic [CNT_W-1:0] green_cnt,
   output logic [CNT_W-1:0] clear_cnt,
   output logic [2:0]       color,
   output logic             frame_valid,
   output logic             sat
);

   localparam int TMR_MAX = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
   localparam int TMR_W   = $clog2(TMR_MAX + 1);
   localparam int STRK_W  = $clog2(CONFIRM + 1);

   localparam logic [TMR_W-1:0]  c_gate_last   = TMR_W'(GATE_CYCLES - 1);
   localparam logic [TMR_W-1:0]  c_settle_last = TMR_W'(SETTLE_CYCLES - 1);
   localparam logic [1:0]        c_last_filt   = 2'(N_FILT - 1);
   localparam logic [STRK_W-1:0] c_confirm     = STRK_W'(CONFIRM);

   scan_state_t       r_state;
   logic [TMR_W-1:0]  r_timer;
   logic [1:0]        r_filt_idx;
   logic              r_frame_sat;
   logic [STRK_W-1:0] r_streak;
   logic [2:0]        r_last_class;

   logic [CNT_W-1:0]  w_cnt;
   logic              w_cnt_sat;
   logic              w_count_en;
   logic              w_clear;
   logic              w_abort;
   logic [2:0]        w_class;
   logic [STRK_W-1:0] w_next_streak;

   assign S0         = scale[0];
   assign S1         = scale[1];
   assign {S3, S2}   = filt_code(r_filt_idx);

   assign w_count_en = (r_state == ST_GATE);
   assign w_clear    = (r_state != ST_GATE);
   // A finished frame in CLASSIFY is never discarded; only an unfinished one is
   assign w_abort    = !en && ((r_state == ST_SETTLE) || (r_state == ST_GATE) ||
                               (r_state == ST_LATCH));

   freq_edge_counter #(
      .CNT_W (CNT_W)
   ) u_edge_counter (
      .clk      (clk),
      .rst      (rst),
      .signal   (signal),
      .count_en (w_count_en),
      .clear    (w_clear),
      .count    (w_cnt),
      .sat      (w_cnt_sat)
   );

   always_comb begin
      w_class       = classify(32'(red_cnt), 32'(blue_cnt), 32'(green_cnt));
      w_next_streak = STRK_W'(1);
      if ((r_streak != '0) && (w_class == r_last_class))
         w_next_streak = (r_streak == c_confirm) ? r_streak : r_streak + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_timer      <= '0;
         r_filt_idx   <= '0;
         r_frame_sat  <= 1'b0;
         r_streak     <= '0;
         r_last_class <= c_class_none;
         red_cnt      <= '0;
         blue_cnt     <= '0;
         green_cnt    <= '0;
         clear_cnt    <= '0;
         color        <= c_class_none;
         frame_valid  <= 1'b0;
         sat          <= 1'b0;
      end else begin
         frame_valid <= 1'b0;
         if (w_abort) begin
            r_state     <= ST_IDLE;
            r_timer     <= '0;
            r_filt_idx  <= '0;
            r_frame_sat <= 1'b0;
            r_streak    <= '0;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (en) begin
                     r_state    <= ST_SETTLE;
                     r_timer    <= '0;
                     r_filt_idx <= '0;
                  end
               end
               ST_SETTLE: begin
                  if (r_timer == c_settle_last) begin
                     r_state <= ST_GATE;
                     r_timer <= '0;
                  end else begin
                     r_timer <= r_timer + 1'b1;
                  end
               end
               ST_GATE: begin
                  if (r_timer == c_gate_last) begin
                     r_state <= ST_LATCH;
                     r_timer <= '0;
                  end else begin
                     r_timer <= r_timer + 1'b1;
                  end
               end
               ST_LATCH: begin
                  case (r_filt_idx)
                     2'd0:    red_cnt   <= w_cnt;
                     2'd1:    blue_cnt  <= w_cnt;
                     2'd2:    green_cnt <= w_cnt;
                     default: clear_cnt <= w_cnt;
                  endcase
                  r_frame_sat <= r_frame_sat | w_cnt_sat;
                  r_timer     <= '0;
                  if (r_filt_idx == c_last_filt) begin
                     r_state <= ST_CLASSIFY;
                  end else begin
                     r_filt_idx <= r_filt_idx + 1'b1;
                     r_state    <= ST_SETTLE;
                  end
               end
               ST_CLASSIFY: begin
                  frame_valid  <= 1'b1;
                  sat          <= r_frame_sat;
                  r_frame_sat  <= 1'b0;
                  r_streak     <= w_next_streak;
                  r_last_class <= w_class;
                  if (w_next_streak == c_confirm)
                     color <= w_class;
                  r_filt_idx   <= '0;
                  r_timer      <= '0;
                  r_state      <= en ? ST_SETTLE : ST_IDLE;
               end
               default: begin
                  r_state <= ST_IDLE;
                  r_timer <= '0;
               end
            endcase
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_colour_sensor_scan.sv
//==============================================================================
// Module   : tb_colour_sensor_scan
// Brief    : Directed self-checking bench for colour_sensor_scan.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_colour_sensor_scan;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic [1:0] scale;
   logic       signal;

   logic       S0, S1, S2, S3;
   logic [6:0] red_cnt, blue_cnt, green_cnt, clear_cnt;
   logic [2:0] color;
   logic       frame_valid, sat;

   logic       x_S0, x_S1, x_S2, x_S3;
   logic [6:0] x_red_cnt, x_blue_cnt, x_green_cnt, x_clear_cnt;
   logic [2:0] x_color;
   logic       x_frame_valid, x_sat;

   int         n_checks = 0;
   int         n_fail   = 0;
   int         t;
   int         since;
   logic [1:0] last_filt;
   int         mode;
   int         per;
   int         ph;

   always #5 clk = ~clk;

   colour_sensor_scan #(
      .GATE_CYCLES(100), .SETTLE_CYCLES(10), .CNT_W(7), .N_FILT(3), .CONFIRM(2)
   ) dut (
      .clk(clk), .rst(rst), .en(en), .scale(scale), .signal(signal),
      .S0(S0), .S1(S1), .S2(S2), .S3(S3),
      .red_cnt(red_cnt), .blue_cnt(blue_cnt), .green_cnt(green_cnt), .clear_cnt(clear_cnt),
      .color(color), .frame_valid(frame_valid), .sat(sat)
   );

   // Long window so a 2-cycle-period signal overruns the 7-bit counter
   colour_sensor_scan #(
      .GATE_CYCLES(300), .SETTLE_CYCLES(10), .CNT_W(7), .N_FILT(3), .CONFIRM(2)
   ) dut_sat (
      .clk(clk), .rst(rst), .en(en), .scale(scale), .signal(signal),
      .S0(x_S0), .S1(x_S1), .S2(x_S2), .S3(x_S3),
      .red_cnt(x_red_cnt), .blue_cnt(x_blue_cnt), .green_cnt(x_green_cnt),
      .clear_cnt(x_clear_cnt), .color(x_color), .frame_valid(x_frame_valid), .sat(x_sat)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0d, expected %0d (t=%0d)", tag, obs, exp, t);
      end
   endtask

   task automatic drive_sig();
      int n;
      case (mode)
         1: signal = ((((t - ph) % per) + per) % per) < (per / 2);
         2: begin
            n = (last_filt == 2'b00) ? 8 : (last_filt == 2'b10) ? 12 :
                (last_filt == 2'b11) ? 2 : 0;
            signal = (since >= 20) && (since < 20 + 4 * n) && (((since - 20) % 4) < 2);
         end
         default: signal = 1'b0;
      endcase
   endtask

   // One clock: value driven at negedge t is sampled by posedge number t
   task automatic step();
      @(negedge clk);
      t = t + 1;
      if ({S3, S2} != last_filt) begin
         last_filt = {S3, S2};
         since     = 0;
      end else begin
         since = since + 1;
      end
      drive_sig();
   endtask

   task automatic hold_reset(input logic [1:0] sc);
      rst    = 1'b1;
      en     = 1'b0;
      mode   = 0;
      signal = 1'b0;
      scale  = sc;
      repeat (3) @(negedge clk);
   endtask

   task automatic start_run(input int m);
      rst       = 1'b0;
      en        = 1'b1;
      mode      = m;
      t         = 0;
      since     = 0;
      last_filt = {S3, S2};
      drive_sig();
   endtask

   task automatic wait_fv(input bit use_sat, input int limit, output int when);
      when = -1;
      for (int i = 0; i < limit; i++) begin
         step();
         if ((use_sat ? x_frame_valid : frame_valid) === 1'b1) begin
            when = t;
            break;
         end
      end
   endtask

   initial begin
      int w1;
      int w2;
      int pulses;

      t = 0;
      // Reset values, scale pins live during reset
      hold_reset(2'b01);
      check_eq("rst_red",    red_cnt, 0);
      check_eq("rst_blue",   blue_cnt, 0);
      check_eq("rst_green",  green_cnt, 0);
      check_eq("rst_clear",  clear_cnt, 0);
      check_eq("rst_color",  color, 3'b000);
      check_eq("rst_fv",     frame_valid, 0);
      check_eq("rst_sat",    sat, 0);
      check_eq("rst_s3s2",   {S3, S2}, 2'b00);
      check_eq("rst_s1s0",   {S1, S0}, 2'b01);

      // Period-12 signal: 8 edges per window, class none, frame every 334 cycles
      per = 12; ph = 7;
      start_run(1);
      wait_fv(1'b0, 400, w1);
      check_eq("p12_fv_time", w1, 335);
      check_eq("p12_red",   red_cnt, 8);
      check_eq("p12_blue",  blue_cnt, 8);
      check_eq("p12_green", green_cnt, 8);
      check_eq("p12_clear", clear_cnt, 0);
      check_eq("p12_color", color, 3'b000);
      check_eq("p12_sat",   sat, 0);
      step();
      check_eq("p12_fv_pulse", frame_valid, 0);
      wait_fv(1'b0, 400, w2);
      check_eq("p12_fv_period", w2 - w1, 334);

      // Period-2 signal: 50 edges per 100-cycle window, saturates a 300-cycle window
      hold_reset(2'b00);
      per = 2; ph = 0;
      start_run(1);
      wait_fv(1'b0, 400, w1);
      check_eq("p2_fv_time", w1, 335);
      check_eq("p2_red",   red_cnt, 50);
      check_eq("p2_blue",  blue_cnt, 50);
      check_eq("p2_green", green_cnt, 50);
      check_eq("p2_sat",   sat, 0);
      wait_fv(1'b1, 700, w2);
      check_eq("sat_fv_time", w2, 935);
      check_eq("sat_red",   x_red_cnt, 127);
      check_eq("sat_blue",  x_blue_cnt, 127);
      check_eq("sat_green", x_green_cnt, 127);
      check_eq("sat_flag",  x_sat, 1);

      // Red-class bursts: colour confirmed on the second frame only; then reset mid-GATE
      hold_reset(2'b10);
      start_run(2);
      wait_fv(1'b0, 400, w1);
      check_eq("red1_fv_time", w1, 335);
      check_eq("red1_red",   red_cnt, 8);
      check_eq("red1_blue",  blue_cnt, 12);
      check_eq("red1_green", green_cnt, 2);
      check_eq("red1_color", color, 3'b000);
      wait_fv(1'b0, 400, w2);
      check_eq("red2_fv_time", w2, 669);
      check_eq("red2_color", color, 3'b001);
      check_eq("run_s1s0", {S1, S0}, 2'b10);
      while (t < 800) step();
      check_eq("pre_rst_s3s2", {S3, S2}, 2'b10);
      rst = 1'b1;
      step();
      check_eq("mid_rst_red",   red_cnt, 0);
      check_eq("mid_rst_blue",  blue_cnt, 0);
      check_eq("mid_rst_green", green_cnt, 0);
      check_eq("mid_rst_color", color, 3'b000);
      check_eq("mid_rst_fv",    frame_valid, 0);
      check_eq("mid_rst_sat",   sat, 0);
      check_eq("mid_rst_s3s2",  {S3, S2}, 2'b00);
      check_eq("mid_rst_s1s0",  {S1, S0}, 2'b10);

      // Enable dropped during blue GATE of frame 2, then restarted
      hold_reset(2'b00);
      start_run(2);
      wait_fv(1'b0, 400, w1);
      check_eq("ab_fv1_time", w1, 335);
      check_eq("ab_fv1_color", color, 3'b000);
      while (t < 500) step();
      en = 1'b0;
      pulses = 0;
      for (int i = 0; i < 400; i++) begin
         step();
         if (frame_valid === 1'b1) pulses++;
      end
      check_eq("ab_no_fv",    pulses, 0);
      check_eq("ab_red",      red_cnt, 8);
      check_eq("ab_blue",     blue_cnt, 12);
      check_eq("ab_green",    green_cnt, 2);
      check_eq("ab_color",    color, 3'b000);
      en    = 1'b1;
      since = 0;
      drive_sig();
      step();
      check_eq("re_s3s2", {S3, S2}, 2'b00);
      wait_fv(1'b0, 400, w1);
      check_eq("re_fv_time", w1, 1235);
      check_eq("re_red",     red_cnt, 8);
      check_eq("re_color1",  color, 3'b000);
      wait_fv(1'b0, 400, w2);
      check_eq("re_fv2_time", w2, 1569);
      check_eq("re_color2",  color, 3'b001);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
